// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package disp_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/scan_timer.sv
// Slot counter: strobes the last BLANK cycle (blank_done_o) and the last SHOW cycle (slot_done_o).
module scan_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic show_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign blank_done_o = !show_i && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
  assign slot_done_o  = show_i && (cnt_q == CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1));

  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses a zero in the most significant digit.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic                    blink_phase_i,
  output logic [3:0]              digit_bcd_o,
  output logic [NUM_DIGITS-1:0]   digit_en_n_o,
  output logic                    frame_start_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  scan_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  bcd_t                    bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
  logic                    frame_q, frame_d;
  logic                    blank_done, slot_done, timer_clear;
  bcd_t                    snap_arr [NUM_DIGITS];
  bcd_t                    snap_digit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
      assign snap_arr[gi] = snap_d[4*gi +: 4];
    end
  endgenerate

  // The counter restarts on every state change and is held at zero while idle.
  assign timer_clear = (state_d != state_q) || (state_q == IDLE);

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (timer_clear),
    .show_i      (state_q == SHOW),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    frame_d = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          snap_d  = digits_i;
          frame_d = 1'b1;
        end
        BLANK: begin
          if (blank_done) state_d = SHOW;
        end
        SHOW: begin
          if (slot_done) begin
            state_d = BLANK;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d   = '0;
              snap_d  = digits_i;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they line up with state_q after the edge.
  always_comb begin
    snap_digit = snap_arr[idx_d];
    bcd_d      = BCD_BLANK;
    en_n_d     = '1;
    if (state_d == SHOW) begin
      en_n_d[idx_d] = 1'b0;
      bcd_d = (blink_mask_i[idx_d] && !blink_phase_i) ? BCD_BLANK : snap_digit;
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_d == IDX_W'(NUM_DIGITS - 1)) && (snap_digit == 4'd0)) begin
        en_n_d = '1;
        bcd_d  = BCD_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= {NUM_DIGITS{BCD_BLANK}};
      bcd_q   <= BCD_BLANK;
      en_n_q  <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      en_n_q  <= en_n_d;
      frame_q <= frame_d;
    end
  end

  assign digit_bcd_o   = bcd_q;
  assign digit_en_n_o  = en_n_q;
  assign frame_start_o = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position model checked every cycle plus literal slot tables.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [15:0]   digits;
  logic [3:0]    mask;
  logic          phase;
  logic [3:0]    digit_bcd;
  logic [3:0]    digit_en_n;
  logic          frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  display_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .digits_i     (digits),
    .blink_mask_i (mask),
    .blink_phase_i(phase),
    .digit_bcd_o  (digit_bcd),
    .digit_en_n_o (digit_en_n),
    .frame_start_o(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position within the frame since the last enable, plus a per-frame copy of the digits.
  bit          m_active;
  int          m_pos;
  logic [15:0] m_snap;
  logic        m_fs;
  logic [3:0]  m_en;
  logic [3:0]  m_bcd;

  always @(posedge clk or negedge rst_n) begin
    int slot, off;
    if (!rst_n) begin
      m_active = 0;
      m_pos    = 0;
      m_snap   = 16'hFFFF;
      m_fs     = 1'b0;
      m_en     = 4'hF;
      m_bcd    = 4'hF;
    end else begin
      m_fs = 1'b0;
      if (!enable) begin
        m_active = 0;
      end else if (!m_active) begin
        m_active = 1;
        m_pos    = 0;
        m_snap   = digits;
        m_fs     = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % (N * R);
        if (m_pos == 0) begin
          m_snap = digits;
          m_fs   = 1'b1;
        end
      end
      m_en  = 4'hF;
      m_bcd = 4'hF;
      if (m_active) begin
        slot = m_pos / R;
        off  = m_pos % R;
        if (off >= B) begin
          m_en  = ~(4'b0001 << slot);
          m_bcd = m_snap[4*slot +: 4];
          if (mask[slot] && !phase) m_bcd = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
          if (slot == N - 1 && m_snap[4*slot +: 4] == 4'd0) begin
            m_en  = 4'hF;
            m_bcd = 4'hF;
          end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_checks++;
      if (digit_en_n !== m_en || digit_bcd !== m_bcd || frame_start !== m_fs) begin
        n_fail++;
        $display("FAIL model t=%0t: en=%b bcd=%h fs=%b, expected en=%b bcd=%h fs=%b",
                 $time, digit_en_n, digit_bcd, frame_start, m_en, m_bcd, m_fs);
      end
      n_checks++;
      if ($countones(~digit_en_n) > 1) begin
        n_fail++;
        $display("FAIL onehot t=%0t: en=%b, required at most one low", $time, digit_en_n);
      end
    end
  end

  logic [3:0] en_tab  [4]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] bcd_tab [7][4] = '{'{4'h4, 4'h3, 4'h2, 4'h1},
                                 '{4'h4, 4'h3, 4'h2, 4'h1},
                                 '{4'h8, 4'h7, 4'h6, 4'h5},
                                 '{4'h8, 4'h7, 4'h6, 4'h5},
                                 '{4'h8, 4'h7, 4'h6, 4'h5},
                                 '{4'h0, 4'h3, 4'h9, 4'h0},
                                 '{4'h0, 4'h3, 4'h9, 4'h0}};

  task automatic lit(input string nm, input logic [3:0] e_en, input logic [3:0] e_bcd,
                     input logic e_fs);
    n_checks++;
    if (digit_en_n !== e_en || digit_bcd !== e_bcd || frame_start !== e_fs) begin
      n_fail++;
      $display("FAIL %s: en=%b bcd=%h fs=%b, expected en=%b bcd=%h fs=%b",
               nm, digit_en_n, digit_bcd, frame_start, e_en, e_bcd, e_fs);
    end
  endtask

  // Checks one frame cycle by cycle up to (stop_s, stop_c), applying the scripted input changes.
  task automatic run_frame(input int f, input int stop_s, input int stop_c);
    logic [3:0] e_en, e_bcd;
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < R; c++) begin
        if (s > stop_s || (s == stop_s && c > stop_c)) return;
        @(negedge clk);
        e_en  = (c < B) ? 4'hF : en_tab[s];
        e_bcd = (c < B) ? 4'hF : bcd_tab[f][s];
        if (c >= B && f == 3 && (s == 0 || (s == 1 && c < 4))) e_bcd = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        if (c >= B && f >= 5 && s == 3) begin
          e_en  = 4'hF;
          e_bcd = 4'hF;
        end
`endif
        lit($sformatf("frame%0d slot%0d cyc%0d", f, s, c), e_en, e_bcd, (s == 0 && c == 0));
        $display("frame %0d slot %0d cyc %0d: en=%b bcd=%h fs=%b",
                 f, s, c, digit_en_n, digit_bcd, frame_start);
        if (f == 1 && s == 1 && c == 3) digits = 16'h5678;
        if (f == 2 && s == 3 && c == 7) begin
          mask  = 4'b0011;
          phase = 1'b0;
        end
        if (f == 3 && s == 1 && c == 3) phase = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    digits = 16'h0000;
    mask   = 4'b0000;
    phase  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lit("reset state", 4'hF, 4'hF, 1'b0);
    @(negedge clk);
    chk_on = 1;
    lit("idle after reset", 4'hF, 4'hF, 1'b0);

    digits = 16'h1234;
    enable = 1'b1;
    run_frame(0, 3, 7);
    run_frame(1, 3, 7);
    run_frame(2, 3, 7);
    run_frame(3, 3, 7);
    run_frame(4, 2, 4);

    enable = 1'b0;
    @(negedge clk);
    lit("disable", 4'hF, 4'hF, 1'b0);
    repeat (3) begin
      @(negedge clk);
      lit("idle while disabled", 4'hF, 4'hF, 1'b0);
    end

    digits = 16'h0930;
    enable = 1'b1;
    run_frame(5, 3, 7);
    run_frame(6, 1, 4);

    #2 rst_n = 1'b0;
    #1 lit("async reset mid show", 4'hF, 4'hF, 1'b0);
    $display("async reset: en=%b bcd=%h fs=%b", digit_en_n, digit_bcd, frame_start);
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      lit("idle after reset release", 4'hF, 4'hF, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
